glm_domain_layer_pipe: RTL

Parametrised, pipelined layer of GLM first-order domain cells for the masked PRINCE S-box datapath. It evaluates the xxxy domain function on NIB nibbles in parallel, with a register stage as a glitch barrier before and after the nonlinear logic. A valid/ready handshake with full backpressure, per-lane masking, a flush, and a saturating transfer counter make it usable both in the round pipeline and standalone under leakage evaluation.

---
 rtl/glm_domain_layer_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/glm_domain_layer_pipe.sv
// -----------------------------------------------------------------------------
// glm_domain_layer_pipe
//
// Pipelined layer of GLM first-order domain cells for the masked PRINCE S-box
// datapath. Each of NIB nibble lanes evaluates the xxxy domain function. A
// register stage sits before (S1) and after (S2) the nonlinear logic so that
// the logic only ever sees settled flop outputs (glitch barrier) and there is
// no combinational path from in_data to out_data.
//
// Parameters
//   NIB    number of nibble lanes, legal 1..64 (16 = full 64-bit state)
//   CNT_W  width of the saturating transfer counter
//
// Ports
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset (wins over flush)
//   flush     synchronous drop of all in-flight words
//   in_valid  / in_ready   input handshake
//   in_data   [4*NIB-1:0]  lane i = {y, x2, x1, x0} at bits [4i+3:4i]
//   lane_en   [NIB-1:0]    per-lane enable, sampled together with in_data
//   out_valid / out_ready  output handshake
//   out_data  [8*NIB-1:0]  lane i = {t3,t2,t1,t0,s3,s2,s1,s0} at [8i+7:8i]
//   xfer_cnt  [CNT_W-1:0]  completed output handshakes, saturating
//
// Handshake semantics (both ports): a word moves exactly on a cycle where
// valid and ready are both 1 at the rising edge. A producer holding valid
// keeps its data stable until the transfer; out_data is held stable while
// out_valid=1 and out_ready=0. in_ready may depend combinationally on
// out_ready, never on in_valid.
// -----------------------------------------------------------------------------
module glm_domain_layer_pipe #(
  parameter int NIB   = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*NIB-1:0]   in_data,
  input  logic [NIB-1:0]     lane_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*NIB-1:0]   out_data,
  output logic [CNT_W-1:0]   xfer_cnt
);

  // xxxy domain function of one lane: n = {y, x2, x1, x0}.
  function automatic logic [7:0] domain_f(input logic [3:0] n);
    logic x0, x1, x2, y;
    logic s0, s1, s2, s3, t0, t1, t2, t3;
    x0 = n[0];
    x1 = n[1];
    x2 = n[2];
    y  = n[3];
    s0 = (x0 & x1 & x2) ^ (x1 & x2) ^ (x0 & x1) ^ y;
    s1 = (x0 & x1 & x2) ^ (x1 & x2 & y) ^ (x0 & x2) ^ ~(x1 & x2);
    s2 = (x0 & x1 & y) ^ (x1 & x2 & y) ^ (x0 & y) ^ (x1 & y);
    s3 = ~(x0 & x1) ^ (x0 & y) ^ (x0 & x1 & x2) ^ (x0 & x1 & y)
       ^ (x0 & x2 & y);
    t0 = (x0 & x1 & y) ^ (x0 & x2 & y) ^ (x1 & x2) ^ (x0 & x1);
    t1 = (x0 & x1 & x2) ^ (x0 & x2) ^ ~(x1 & x2);
    t2 = (x0 & x1 & x2) ^ (x0 & x1 & y) ^ (x0 & x2) ^ (x1 & x2) ^ x0;
    t3 = ~x1 ^ (x0 & x1) ^ (x1 & x2) ^ (x0 & y) ^ (x1 & y)
       ^ (x0 & x1 & x2) ^ (x0 & x2 & y) ^ (x1 & x2 & y);
    return {t3, t2, t1, t0, s3, s2, s1, s0};
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: masked input nibbles, lane enables, valid.
  logic [4*NIB-1:0] s1_data;
  logic [NIB-1:0]   s1_en;
  logic             s1_valid;

  // Stage 2: domain outputs, valid.
  logic [8*NIB-1:0] s2_data;
  logic             s2_valid;

  logic             s2_adv;
  logic             in_fire;
  logic             out_fire;
  logic [4*NIB-1:0] in_masked;
  logic [8*NIB-1:0] s2_next;

  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid & out_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  // Disabled lanes enter S1 as zero so no secret share lingers in the flops.
  always_comb begin
    in_masked = '0;
    for (int i = 0; i < NIB; i++) begin
      in_masked[4*i +: 4] = lane_en[i] ? in_data[4*i +: 4] : 4'h0;
    end
  end

  // Domain logic is fed from S1 flops only. A disabled lane is forced to
  // 8'h00 rather than f(0), which would otherwise be 8'hAA.
  always_comb begin
    s2_next = '0;
    for (int i = 0; i < NIB; i++) begin
      s2_next[8*i +: 8] = s1_en[i] ? domain_f(s1_data[4*i +: 4]) : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_en    <= '0;
      s1_valid <= 1'b0;
      s2_data  <= '0;
      s2_valid <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      // An output handshake in a flush cycle still completes and counts.
      if (out_fire && (xfer_cnt != CNT_MAX)) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end

      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv) begin
          s2_data  <= s2_next;
          s2_valid <= 1'b1;
        end else if (out_fire) begin
          s2_valid <= 1'b0;
        end

        if (in_fire) begin
          s1_data  <= in_masked;
          s1_en    <= lane_en;
          s1_valid <= 1'b1;
        end else if (s2_adv) begin
          s1_valid <= 1'b0;
        end
      end
    end
  end

endmodule
